// File: rtl/div16x8.sv
`default_nettype none
// ============================================================================
// Module   : div16x8
// Purpose  : Iterative restoring unsigned divider, 16-bit / 8-bit, one
//            quotient bit per clock, start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module div16x8 #(
    parameter int NW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] N,
    input  logic [DW-1:0] D,
    output logic [NW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          busy,
    output logic          done,
    output logic          div0
);

    localparam int            c_CNT_W    = $clog2(NW);
    localparam [c_CNT_W-1:0]  c_CNT_INIT = c_CNT_W'(NW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NW-1:0]      r_dvd;
    logic [DW-1:0]      r_dsr;
    logic [DW-1:0]      r_rem;
    logic [c_CNT_W-1:0] r_cnt;

    logic [DW:0]        w_t;
    logic [DW:0]        w_diff;
    logic               w_ge;
    logic [DW-1:0]      w_rem_nxt;
    logic [NW-1:0]      w_dvd_nxt;

    // The partial remainder is always below the divisor, so t < 2*dsr and the
    // top bit of t - dsr is a reliable borrow flag; only DW remainder bits are kept.
    assign w_t       = {r_rem, r_dvd[NW-1]};
    assign w_diff    = w_t - {1'b0, r_dsr};
    assign w_ge      = ~w_diff[DW];
    assign w_rem_nxt = w_ge ? w_diff[DW-1:0] : w_t[DW-1:0];
    assign w_dvd_nxt = {r_dvd[NW-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            Q       <= '0;
            R       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd <= N;
                        r_dsr <= D;
                        r_rem <= '0;
                        r_cnt <= c_CNT_INIT;
                        if (D == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            Q       <= '1;
                            R       <= N[DW-1:0];
                            div0    <= 1'b1;
                        end else begin
                            r_state <= S_BUSY;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_dvd <= w_dvd_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        Q       <= w_dvd_nxt;
                        R       <= w_rem_nxt;
                        div0    <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div16x8.sv
`default_nettype none
// ============================================================================
// Module   : tb_div16x8
// Purpose  : Self-checking bench for div16x8: directed table, handshake and
//            reset sequences, and randomized checks against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div16x8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] N;
    logic [7:0]  D;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        busy;
    logic        done;
    logic        div0;

    int vectors;
    int miscompares;

    div16x8 #(.NW(16), .DW(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .div0  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic [15:0] q;
        logic [7:0]  r;
        bit          z;
        int          lat;
        int          nbusy;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves one idle cycle, issues a start, and waits (bounded) for done.
    task automatic do_div(input logic [15:0] n, input logic [7:0] d,
                          output int lat, output int nbusy, output bit to);
        tick();
        N = n;
        D = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        nbusy = 0;
        to = 1'b0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        if (!done) to = 1'b1;
    endtask

    // Reference model: plain integer division with the divide-by-zero convention.
    task automatic model(input logic [15:0] n, input logic [7:0] d,
                         output logic [15:0] q, output logic [7:0] r, output bit z);
        if (d == 0) begin
            q = 16'hFFFF;
            r = n[7:0];
            z = 1'b1;
        end else begin
            q = 16'(int'(n) / int'(d));
            r = 8'(int'(n) % int'(d));
            z = 1'b0;
        end
    endtask

    initial begin
        int lat, nbusy, cnt;
        bit to;
        logic [15:0] mq;
        logic [7:0]  mr;
        bit          mz;
        bit          seen;

        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        start = 1'b0;
        N = '0;
        D = '0;

        tbl[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17, 16};
        tbl[1] = '{16'd65025, 8'd255, 16'd255,   8'd0,   1'b0, 17, 16};
        tbl[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 17, 16};
        tbl[3] = '{16'd5,     8'd10,  16'd0,     8'd5,   1'b0, 17, 16};
        tbl[4] = '{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 1,  0};
        tbl[5] = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 17, 16};
        tbl[6] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 17, 16};

        tick();
        tick();
        chk("reset_q", Q, 0);
        chk("reset_r", R, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_div0", div0, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_div(tbl[i].n, tbl[i].d, lat, nbusy, to);
            chk($sformatf("tbl%0d_timeout", i), to, 0);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_busycycles", i), nbusy, tbl[i].nbusy);
            chk($sformatf("tbl%0d_q", i), Q, tbl[i].q);
            chk($sformatf("tbl%0d_r", i), R, tbl[i].r);
            chk($sformatf("tbl%0d_div0", i), div0, tbl[i].z);
            chk($sformatf("tbl%0d_busy_at_done", i), busy, 0);
            tick();
            chk($sformatf("tbl%0d_done_pulse", i), done, 0);
            chk($sformatf("tbl%0d_q_held", i), Q, tbl[i].q);
        end

        // Start held high with operands changing mid-division.
        tick();
        N = 16'd1000;
        D = 8'd7;
        start = 1'b1;
        tick();
        N = 16'd50000;
        D = 8'd3;
        cnt = 1;
        while (!done && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("hold_latency", cnt, 17);
        chk("hold_q", Q, 142);
        chk("hold_r", R, 6);
        tick();
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_done", done, 0);
        tick();
        chk("hold_retrigger_busy", busy, 1);
        start = 1'b0;
        tick();
        chk("hold_q_stable_while_busy", Q, 142);
        cnt = 0;
        while (!done && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("hold2_timeout", done, 1);
        chk("hold2_q", Q, 16666);
        chk("hold2_r", R, 2);

        // Reset in the middle of a division, with start asserted alongside it.
        tick();
        N = 16'd40000;
        D = 8'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        start = 1'b1;
        tick();
        chk("abort_q", Q, 0);
        chk("abort_r", R, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_div0", div0, 0);
        rst = 1'b0;
        start = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        do_div(16'd40000, 8'd13, lat, nbusy, to);
        chk("abort_fresh_timeout", to, 0);
        chk("abort_fresh_q", Q, 3076);
        chk("abort_fresh_r", R, 12);

        // Operands built from the multiplier view: N = A*B + r with r < B.
        for (int i = 0; i < 2000; i++) begin
            int a, b, r, n;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            r = int'($urandom_range(0, b - 1));
            n = a * b + r;
            do_div(16'(n), 8'(b), lat, nbusy, to);
            chk("rnd_timeout", to, 0);
            chk("rnd_q", Q, a);
            chk("rnd_r", R, r);
            chk("rnd_div0", div0, 0);
            chk("rnd_identity", int'(Q) * b + int'(R), n);
            chk("rnd_r_lt_d", int'(R) < b, 1);
        end

        // Full-range operands, divisor zero included.
        for (int i = 0; i < 200; i++) begin
            logic [15:0] n;
            logic [7:0]  d;
            n = 16'($urandom);
            d = (i % 10 == 0) ? 8'd0 : 8'($urandom);
            model(n, d, mq, mr, mz);
            do_div(n, d, lat, nbusy, to);
            chk("full_timeout", to, 0);
            chk("full_q", Q, mq);
            chk("full_r", R, mr);
            chk("full_div0", div0, mz);
            chk("full_latency", lat, mz ? 1 : 17);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
